// File: rtl/fft32_out_serializer_if.sv
// Bundle of the parallel frame input and the serial word output of the
// fft32 output serializer. The frame side carries 32 complex words
// (real in [63:32], imaginary in [31:0]); the stream side is valid/ready.
interface fft32_out_serializer_if;
  logic [63:0] i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7;
  logic [63:0] i8,  i9,  i10, i11, i12, i13, i14, i15;
  logic [63:0] i16, i17, i18, i19, i20, i21, i22, i23;
  logic [63:0] i24, i25, i26, i27, i28, i29, i30, i31;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  // Serializer side: consumes the frame, produces the stream.
  modport slave (
    input  i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7,
           i8,  i9,  i10, i11, i12, i13, i14, i15,
           i16, i17, i18, i19, i20, i21, i22, i23,
           i24, i25, i26, i27, i28, i29, i30, i31,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_index,
    output out_last,
    output out_valid,
    input  out_ready
  );

  // Environment side: produces the frame, consumes the stream.
  modport master (
    output i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7,
           i8,  i9,  i10, i11, i12, i13, i14, i15,
           i16, i17, i18, i19, i20, i21, i22, i23,
           i24, i25, i26, i27, i28, i29, i30, i31,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_index,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fft32_out_serializer.sv
// Captures a 32-word frame from the final butterfly stage in one cycle and
// replays it one word per cycle in index order 0..31. Outputs are decoded
// only from registered state, so upstream data never reaches the outputs
// combinationally. A capture on the same edge that hands off word 31
// allows back-to-back frames with no gap.
module fft32_out_serializer (
  input  logic                         clk,
  input  logic                         rst_n,
  fft32_out_serializer_if.slave        bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_next_s;
  logic [63:0] buf_r [32];
  logic [63:0] frame_s [32];
  logic        in_ready_s;
  logic        capture_s;
  logic        advance_s;
  logic        at_last_s;

  assign frame_s = '{bus.i0,  bus.i1,  bus.i2,  bus.i3,
                     bus.i4,  bus.i5,  bus.i6,  bus.i7,
                     bus.i8,  bus.i9,  bus.i10, bus.i11,
                     bus.i12, bus.i13, bus.i14, bus.i15,
                     bus.i16, bus.i17, bus.i18, bus.i19,
                     bus.i20, bus.i21, bus.i22, bus.i23,
                     bus.i24, bus.i25, bus.i26, bus.i27,
                     bus.i28, bus.i29, bus.i30, bus.i31};

  assign at_last_s = (cnt_r == 5'd31);

  // Handshake decode and next-state: accept a frame when idle or when the
  // last word is leaving this cycle; advance the read counter on handoff.
  always_comb begin
    in_ready_s   = 1'b0;
    advance_s    = 1'b0;
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        in_ready_s = rst_n;
        advance_s  = 1'b0;
      end
      STREAM: begin
        in_ready_s = rst_n && at_last_s && bus.out_ready;
        advance_s  = bus.out_ready;
      end
      default: begin
        in_ready_s = 1'b0;
        advance_s  = 1'b0;
      end
    endcase

    capture_s = bus.in_valid && in_ready_s;

    if (capture_s) begin
      state_next_s = STREAM;
      cnt_next_s   = 5'd0;
    end else if (advance_s) begin
      if (at_last_s) begin
        state_next_s = IDLE;
        cnt_next_s   = 5'd0;
      end else begin
        state_next_s = STREAM;
        cnt_next_s   = cnt_r + 5'd1;
      end
    end else begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
    end
  end

  // State and read counter; reset drops any frame in flight at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Frame buffer: cleared by reset, loaded whole on capture, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin
        buf_r[k] <= 64'h0;
      end
    end else if (capture_s) begin
      for (int k = 0; k < 32; k++) begin
        buf_r[k] <= frame_s[k];
      end
    end else begin
      for (int k = 0; k < 32; k++) begin
        buf_r[k] <= buf_r[k];
      end
    end
  end

  // Output decode from registered state: the buffered word at the read
  // counter while streaming, all zeros while idle.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = 64'h0;
    bus.out_index = 5'd0;
    bus.out_last  = 1'b0;
    if (state_r == STREAM) begin
      bus.out_valid = 1'b1;
      bus.out_data  = buf_r[cnt_r];
      bus.out_index = cnt_r;
      bus.out_last  = at_last_s;
    end else begin
      bus.out_valid = 1'b0;
      bus.out_data  = 64'h0;
      bus.out_index = 5'd0;
      bus.out_last  = 1'b0;
    end
  end

  assign bus.in_ready = in_ready_s;

endmodule

// File: tb/tb_fft32_out_serializer.sv
// Directed bench for fft32_out_serializer: a step table for reset and the
// first words of a frame, then hand-written streaming sequences for
// backpressure, ignored input while busy, back-to-back frames and reset
// in the middle of a stream.
module tb_fft32_out_serializer;

  logic clk;
  logic rst_n;
  logic [63:0] tb_frame [32];
  int n_cmp;
  int n_fail;

  fft32_out_serializer_if bus ();

  fft32_out_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.i0  = tb_frame[0];   assign bus.i1  = tb_frame[1];
  assign bus.i2  = tb_frame[2];   assign bus.i3  = tb_frame[3];
  assign bus.i4  = tb_frame[4];   assign bus.i5  = tb_frame[5];
  assign bus.i6  = tb_frame[6];   assign bus.i7  = tb_frame[7];
  assign bus.i8  = tb_frame[8];   assign bus.i9  = tb_frame[9];
  assign bus.i10 = tb_frame[10];  assign bus.i11 = tb_frame[11];
  assign bus.i12 = tb_frame[12];  assign bus.i13 = tb_frame[13];
  assign bus.i14 = tb_frame[14];  assign bus.i15 = tb_frame[15];
  assign bus.i16 = tb_frame[16];  assign bus.i17 = tb_frame[17];
  assign bus.i18 = tb_frame[18];  assign bus.i19 = tb_frame[19];
  assign bus.i20 = tb_frame[20];  assign bus.i21 = tb_frame[21];
  assign bus.i22 = tb_frame[22];  assign bus.i23 = tb_frame[23];
  assign bus.i24 = tb_frame[24];  assign bus.i25 = tb_frame[25];
  assign bus.i26 = tb_frame[26];  assign bus.i27 = tb_frame[27];
  assign bus.i28 = tb_frame[28];  assign bus.i29 = tb_frame[29];
  assign bus.i30 = tb_frame[30];  assign bus.i31 = tb_frame[31];

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        exp_valid;
    logic [4:0]  exp_index;
    logic        exp_last;
    logic        exp_in_ready;
    logic [63:0] exp_data;
  } step_t;

  step_t vec [8];

  function automatic logic [63:0] word_of(input int base, input int k);
    logic [31:0] lo;
    lo = 32'(base + k);
    return {32'h3f80_0000, lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill(input int base);
    for (int k = 0; k < 32; k++) tb_frame[k] = word_of(base, k);
  endtask

  task automatic fill_const(input logic [63:0] v);
    for (int k = 0; k < 32; k++) tb_frame[k] = v;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_data"},  bus.out_data, 64'd0);
    chk({tag, "_last"},  64'(bus.out_last), 64'd0);
    chk({tag, "_index"}, 64'(bus.out_index), 64'd0);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  // Present the frame for one cycle from IDLE and check it is accepted.
  task automatic capture(input int base);
    fill(base);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("capture_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Follow a frame from index k0 to the hand-off of index 31, applying the
  // requested stalls; optionally pulse ignored input at one index, or hold
  // the next frame with in_valid from index next_from onward.
  task automatic stream(input int base, input int k0, input int stall_idx,
                        input int stall_len, input int stall31,
                        input int ignore_at, input int next_base,
                        input int next_from, output int cycles);
    int k;
    int st;
    int st31;
    int guard;
    k = k0; st = 0; st31 = 0; guard = 0; cycles = 0;
    while (k < 32 && guard < 200) begin
      guard++;
      bus.out_ready = 1'b1;
      if (k == stall_idx && st < stall_len) begin
        bus.out_ready = 1'b0; st++;
      end else if (k == 31 && st31 < stall31) begin
        bus.out_ready = 1'b0; st31++;
      end
      bus.in_valid = 1'b0;
      if (k == ignore_at) begin
        fill_const(64'hbf80_0000_0000_0000);
        bus.in_valid = 1'b1;
      end
      if (next_base >= 0 && k >= next_from) begin
        fill(next_base);
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_index", 64'(bus.out_index), 64'(k));
      chk("stream_data",  bus.out_data, word_of(base, k));
      chk("stream_last",  64'(bus.out_last), (k == 31) ? 64'd1 : 64'd0);
      chk("stream_in_ready", 64'(bus.in_ready),
          (k == 31 && bus.out_ready) ? 64'd1 : 64'd0);
      cycles++;
      @(posedge clk); #1;
      if (bus.out_ready) k++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 200) chk("stream_timeout", 64'(guard), 64'd0);
  endtask

  initial begin
    int cyc;
    int cyc_b;
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    fill(0);
    repeat (2) @(posedge clk);
    #1;

    // rst_n in_valid out_ready | valid index last in_ready data
    vec[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 64'h0};
    vec[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 64'h0};
    vec[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 64'h0};
    vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 64'h0};
    vec[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 64'h3f80_0000_0000_0000};
    vec[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 64'h3f80_0000_0000_0001};
    vec[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 64'h3f80_0000_0000_0001};
    vec[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 64'h3f80_0000_0000_0002};

    for (int s = 0; s < 8; s++) begin
      rst_n         = vec[s].rst_n;
      bus.in_valid  = vec[s].in_valid;
      bus.out_ready = vec[s].out_ready;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", s), 64'(bus.out_valid), 64'(vec[s].exp_valid));
      chk($sformatf("vec%0d_index", s), 64'(bus.out_index), 64'(vec[s].exp_index));
      chk($sformatf("vec%0d_last", s), 64'(bus.out_last), 64'(vec[s].exp_last));
      chk($sformatf("vec%0d_in_ready", s), 64'(bus.in_ready), 64'(vec[s].exp_in_ready));
      chk($sformatf("vec%0d_data", s), bus.out_data, vec[s].exp_data);
      @(posedge clk); #1;
    end

    // Rest of the first frame: 3 stall cycles at index 5, 1 at index 31.
    stream(0, 3, 5, 3, 1, -1, -1, 0, cyc);
    chk("backpressure_cycles", 64'(cyc), 64'((32 - 3) + 3 + 1));
    check_idle("after_bp");

    // Free-flowing frame.
    capture(0);
    stream(0, 0, -1, 0, 0, -1, -1, 0, cyc);
    chk("free_cycles", 64'(cyc), 64'd32);
    check_idle("after_free");

    // Input changes and in_valid at index 10 must be ignored.
    capture(0);
    stream(0, 0, -1, 0, 0, 10, -1, 0, cyc);
    chk("ignore_cycles", 64'(cyc), 64'd32);
    check_idle("after_ignore");

    // Back-to-back: frame B held with in_valid from index 20 of frame A.
    capture(0);
    stream(0, 0, -1, 0, 0, -1, 100, 20, cyc);
    stream(100, 0, -1, 0, 0, -1, -1, 0, cyc_b);
    chk("b2b_cycles", 64'(cyc + cyc_b), 64'd64);
    check_idle("after_b2b");

    // Reset at index 17 drops the frame; a fresh frame then plays from 0.
    capture(0);
    bus.out_ready = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_index_before_rst", 64'(bus.out_index), 64'd17);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", bus.out_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check_idle("after_mid_rst");
    capture(50);
    stream(50, 0, -1, 0, 0, -1, -1, 0, cyc);
    chk("restart_cycles", 64'(cyc), 64'd32);
    check_idle("after_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
